// File: rtl/mul8_err_monitor.sv
// mul8_err_monitor
//
// Error-statistics accumulator for an approximate 8x8 multiplier. Each accepted
// sample (a, b, o_approx) has its exact product rebuilt by an 8-cycle shift-add
// multiplier. The block then folds |exact - o_approx| into saturating statistics.
//
// Build option: define ERRMON_MSE_EN to add the sum_sq_err port, the 16x16
// squarer and the SQ_W accumulator. Without it those are absent and all other
// behaviour and timing are unchanged.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset (clears statistics and operand regs)
//   clear        synchronous clear of statistics; aborts any sample in progress
//   in_valid     sample valid
//   in_ready     block can accept a sample (high only in IDLE)
//   a, b         8-bit operands
//   o_approx     16-bit approximate product under test
//   busy         sample in progress (state != IDLE)
//   sample_cnt   completed samples                      (CNT_W, saturating)
//   err_cnt      samples with o_approx != exact         (CNT_W, saturating)
//   sum_abs_err  sum of |exact - o_approx|              (SUM_W, saturating)
//   wce          worst-case |exact - o_approx|          (16)
//   sum_sq_err   sum of squared error, ERRMON_MSE_EN only (SQ_W, saturating)
module mul8_err_monitor #(
    parameter int CNT_W = 17,
    parameter int SUM_W = 34
`ifdef ERRMON_MSE_EN
    ,
    parameter int SQ_W  = 48
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic [15:0]      o_approx,
    output logic             busy,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [SUM_W-1:0] sum_abs_err,
    output logic [15:0]      wce
`ifdef ERRMON_MSE_EN
    ,
    output logic [SQ_W-1:0]  sum_sq_err
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_ACC  = 2'd2;

    logic [1:0]  state;
    logic [2:0]  step;
    logic [7:0]  a_reg;
    logic [7:0]  b_reg;
    logic [15:0] o_reg;
    logic [15:0] exact;
    logic [15:0] partial;
    logic [15:0] diff;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                  input logic en);
        if (en && (v != '1))
            return v + CNT_W'(1);
        return v;
    endfunction

    function automatic logic [SUM_W-1:0] sat_add_sum(input logic [SUM_W-1:0] acc,
                                                      input logic [15:0] d);
        logic [SUM_W:0] s;
        s = {1'b0, acc} + (SUM_W+1)'(d);
        return s[SUM_W] ? '1 : s[SUM_W-1:0];
    endfunction

`ifdef ERRMON_MSE_EN
    function automatic logic [SQ_W-1:0] sat_add_sq(input logic [SQ_W-1:0] acc,
                                                    input logic [31:0] d);
        logic [SQ_W:0] s;
        s = {1'b0, acc} + (SQ_W+1)'(d);
        return s[SQ_W] ? '1 : s[SQ_W-1:0];
    endfunction

    logic [31:0] diff_sq;
    always_comb diff_sq = 32'(diff) * 32'(diff);
`endif

    // Shift-add partial product for the current multiplier bit.
    always_comb partial = b_reg[step] ? ({8'd0, a_reg} << step) : 16'd0;

    // Magnitude of the error: subtract the smaller value from the larger one.
    always_comb diff = (exact >= o_reg) ? (exact - o_reg) : (o_reg - exact);

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            step        <= 3'd0;
            a_reg       <= 8'd0;
            b_reg       <= 8'd0;
            o_reg       <= 16'd0;
            exact       <= 16'd0;
            sample_cnt  <= '0;
            err_cnt     <= '0;
            sum_abs_err <= '0;
            wce         <= 16'd0;
`ifdef ERRMON_MSE_EN
            sum_sq_err  <= '0;
`endif
        end else if (clear) begin
            // Operand registers keep their contents; the sample is simply dropped.
            state       <= ST_IDLE;
            step        <= 3'd0;
            sample_cnt  <= '0;
            err_cnt     <= '0;
            sum_abs_err <= '0;
            wce         <= 16'd0;
`ifdef ERRMON_MSE_EN
            sum_sq_err  <= '0;
`endif
        end else begin
            case (state)
                // Capture the sample at the handshake.
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        o_reg <= o_approx;
                        exact <= 16'd0;
                        step  <= 3'd0;
                        state <= ST_MUL;
                    end
                end
                // Eight shift-add steps build the exact product.
                ST_MUL: begin
                    exact <= exact + partial;
                    step  <= step + 3'd1;
                    if (step == 3'd7)
                        state <= ST_ACC;
                end
                // Fold the finished sample into the statistics.
                ST_ACC: begin
                    sample_cnt  <= sat_inc(sample_cnt, 1'b1);
                    err_cnt     <= sat_inc(err_cnt, diff != 16'd0);
                    sum_abs_err <= sat_add_sum(sum_abs_err, diff);
                    if (diff > wce)
                        wce <= diff;
`ifdef ERRMON_MSE_EN
                    sum_sq_err  <= sat_add_sq(sum_sq_err, diff_sq);
`endif
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul8_err_monitor.sv
// Testbench for mul8_err_monitor: random and directed samples checked every
// cycle against a behavioural model of the statistics, plus literal checks.
module tb_mul8_err_monitor;

    localparam int CNT_W = 5;
    localparam int SUM_W = 16;
    localparam longint unsigned CMAX = (64'd1 << CNT_W) - 1;
    localparam longint unsigned SMAX = (64'd1 << SUM_W) - 1;
    localparam longint unsigned QMAX = (64'd1 << 48) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       a = 8'd0;
    logic [7:0]       b = 8'd0;
    logic [15:0]      o_approx = 16'd0;
    logic             busy;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [SUM_W-1:0] sum_abs_err;
    logic [15:0]      wce;
`ifdef ERRMON_MSE_EN
    logic [47:0]      sum_sq_err;
`endif

    mul8_err_monitor #(.CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .o_approx    (o_approx),
        .busy        (busy),
        .sample_cnt  (sample_cnt),
        .err_cnt     (err_cnt),
        .sum_abs_err (sum_abs_err),
        .wce         (wce)
`ifdef ERRMON_MSE_EN
        ,
        .sum_sq_err  (sum_sq_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input longint unsigned act,
                       input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a sample accepted at a clock edge lands in the
    // statistics nine edges later; clear or reset drops it.
    bit              m_pending = 1'b0;
    int              m_left = 0;
    longint unsigned m_diff = 0;
    longint unsigned m_cnt = 0, m_err = 0, m_sum = 0, m_wce = 0, m_sq = 0;

    always @(posedge clk) begin
        if (!rst_n || clear) begin
            m_pending = 1'b0;
            m_cnt = 0; m_err = 0; m_sum = 0; m_wce = 0; m_sq = 0;
        end else if (m_pending) begin
            m_left--;
            if (m_left == 0) begin
                m_pending = 1'b0;
                m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
                if (m_diff != 0)
                    m_err = (m_err + 1 > CMAX) ? CMAX : m_err + 1;
                m_sum = (m_sum + m_diff > SMAX) ? SMAX : m_sum + m_diff;
                if (m_diff > m_wce) m_wce = m_diff;
                m_sq = (m_sq + m_diff * m_diff > QMAX) ? QMAX : m_sq + m_diff * m_diff;
            end
        end else if (in_valid) begin
            longint signed e;
            e = longint'(a) * longint'(b) - longint'(o_approx);
            m_diff = (e < 0) ? longint'(-e) : longint'(e);
            m_pending = 1'b1;
            m_left = 9;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_in_ready", in_ready, !m_pending);
            chk("m_busy", busy, m_pending);
            chk("m_sample_cnt", sample_cnt, m_cnt);
            chk("m_err_cnt", err_cnt, m_err);
            chk("m_sum_abs_err", sum_abs_err, m_sum);
            chk("m_wce", wce, m_wce);
`ifdef ERRMON_MSE_EN
            chk("m_sum_sq_err", sum_sq_err, m_sq);
`endif
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk({name, "_timeout"}, in_ready, 1);
    endtask

    task automatic send(input logic [7:0] ta, input logic [7:0] tb,
                        input logic [15:0] to);
        wait_ready("send_ready");
        a = ta; b = tb; o_approx = to; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        int n;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_sample_cnt", sample_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_sum", sum_abs_err, 0);
        chk("rst_wce", wce, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Exact sample and its latency
        send(8'd255, 8'd255, 16'd65025);
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("exact_latency", n, 9);
        chk("exact_sample_cnt", sample_cnt, 1);
        chk("exact_err_cnt", err_cnt, 0);
        chk("exact_sum", sum_abs_err, 0);
        chk("exact_wce", wce, 0);

        // Two approximate samples
        do_clear();
        send(8'd3, 8'd5, 16'd20);
        send(8'd10, 8'd10, 16'd90);
        wait_ready("approx_done");
        chk("approx_sample_cnt", sample_cnt, 2);
        chk("approx_err_cnt", err_cnt, 2);
        chk("approx_sum", sum_abs_err, 15);
        chk("approx_wce", wce, 10);
`ifdef ERRMON_MSE_EN
        chk("approx_sq", sum_sq_err, 125);
`endif

        // Backpressure: in_valid held, inputs changing every cycle
        do_clear();
        in_valid = 1'b1;
        a = 8'($urandom); b = 8'($urandom); o_approx = 16'($urandom);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            a = 8'($urandom); b = 8'($urandom); o_approx = 16'($urandom);
        end
        in_valid = 1'b0;
        chk("bp_sample_cnt", sample_cnt, 3);

        // Clear in the 4th MUL cycle
        send(8'd7, 8'd9, 16'd1);
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("midclr_sample_cnt", sample_cnt, 0);
        chk("midclr_err_cnt", err_cnt, 0);
        chk("midclr_sum", sum_abs_err, 0);
        chk("midclr_wce", wce, 0);
        chk("midclr_in_ready", in_ready, 1);
        chk("midclr_busy", busy, 0);

        // clear together with in_valid in IDLE
        clear = 1'b1; in_valid = 1'b1; a = 8'd9; b = 8'd9; o_approx = 16'd0;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        chk("clrv_in_ready", in_ready, 1);
        repeat (12) @(negedge clk);
        chk("clrv_sample_cnt", sample_cnt, 0);

        // Saturation of the 16-bit sum
        send(8'd255, 8'd255, 16'd0);
        send(8'd255, 8'd255, 16'd0);
        wait_ready("sat_done");
        chk("sat_sum", sum_abs_err, 65535);
        chk("sat_wce", wce, 65025);
        chk("sat_err_cnt", err_cnt, 2);

        // Random samples; the count runs past the 5-bit counter limit
        do_clear();
        for (int k = 0; k < 60; k++) begin
            logic [7:0]  ra, rb;
            logic [15:0] ro;
            int          sel;
            ra = 8'($urandom); rb = 8'($urandom);
            sel = $urandom_range(0, 2);
            if (sel == 0) ro = 16'(ra * rb);
            else if (sel == 1) ro = 16'(ra * rb) + 16'($urandom_range(0, 6)) - 16'd3;
            else ro = 16'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(ra, rb, ro);
        end
        wait_ready("rand_done");
        chk("rand_sample_cnt_sat", sample_cnt, 31);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
